// File: rtl/fmac_pkg.sv
// Shared types and helpers for the fused multiply-add/accumulate unit.
package fmac_pkg;

  typedef enum logic [1:0] {
    FMAC_MAD  = 2'b00,
    FMAC_MSB  = 2'b01,
    FMAC_NMAD = 2'b10,
    FMAC_MAC  = 2'b11
  } fmacMode_t;

  typedef enum logic [1:0] {
    FMAC_IDLE,
    FMAC_MUL,
    FMAC_ADD,
    FMAC_DONE
  } fmacState_t;

  // Radix-4 Booth digit count; covers one extra bit for unsigned operands.
  function automatic int mulCycles(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/fmac_if.sv
// Operand/result handshake bundle between a producer and fmac_unit.
interface fmac_if #(
  parameter int WIDTH = 11,
  parameter int GUARD = 4
);
  import fmac_pkg::*;

  localparam int OUTWIDTH = 2*WIDTH + GUARD;

  logic                inValid;
  logic                inReady;
  logic [WIDTH-1:0]    mulIn1;
  logic [WIDTH-1:0]    mulIn2;
  logic [WIDTH-1:0]    addIn;
  fmacMode_t           mode;
  logic                accClear;
  logic                outValid;
  logic                outReady;
  logic [OUTWIDTH-1:0] fmadOut;
  logic                overflow;

  modport master (
    output inValid, mulIn1, mulIn2, addIn, mode, accClear, outReady,
    input  inReady, outValid, fmadOut, overflow
  );

  modport slave (
    input  inValid, mulIn1, mulIn2, addIn, mode, accClear, outReady,
    output inReady, outValid, fmadOut, overflow
  );

endinterface

// File: rtl/radix4_booth_mul.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, exact 2*WIDTH product.
module radix4_booth_mul #(
  parameter int WIDTH  = 11,
  parameter int SIGNED = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mulIn1,
  input  logic [WIDTH-1:0]   mulIn2,
  output logic [2*WIDTH-1:0] mulOut,
  output logic               done
);
  import fmac_pkg::*;

  localparam int N   = mulCycles(WIDTH);
  localparam int PW  = 2*WIDTH;
  localparam int MRW = 2*N;
  localparam int CW  = $clog2(N + 1);
  localparam bit S   = (SIGNED != 0);

  logic [PW-1:0]  mcand;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  term;
  logic [MRW-1:0] mr;
  logic           prev;
  logic           busy;
  logic [CW-1:0]  cnt;

  // Arithmetic is modulo 2^PW, which is enough because the true product fits PW bits.
  always_comb begin
    term = '0;
    case ({mr[1:0], prev})
      3'b001, 3'b010: term = mcand;
      3'b011:         term = mcand << 1;
      3'b100:         term = -(mcand << 1);
      3'b101, 3'b110: term = -mcand;
      default:        term = '0;
    endcase
  end

  assign done   = busy && (cnt == CW'(N - 1));
  assign mulOut = acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand <= '0;
      mr    <= '0;
      prev  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= {{(PW-WIDTH){S & mulIn1[WIDTH-1]}}, mulIn1};
      mr    <= {{(MRW-WIDTH){S & mulIn2[WIDTH-1]}}, mulIn2};
      prev  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc   <= acc + term;
      mcand <= mcand << 2;
      mr    <= mr >> 2;
      prev  <= mr[1];
      cnt   <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/fmac_unit.sv
// Integer fused multiply-add/accumulate with a persistent accumulator and valid/ready handshakes.
module fmac_unit #(
  parameter int WIDTH  = 11,
  parameter int GUARD  = 4,
  parameter int SIGNED = 0
) (
  input logic  clock,
  input logic  reset,
  fmac_if.slave bus
);
  import fmac_pkg::*;

  localparam int OUTWIDTH = 2*WIDTH + GUARD;
  localparam bit S        = (SIGNED != 0);

  typedef struct packed {
    logic [WIDTH-1:0] c;
    fmacMode_t        mode;
    logic             clr;
  } req_t;

  fmacState_t state, state_nxt;
  req_t       req;

  logic                in_ready, out_valid, transfer, mul_done;
  logic [2*WIDTH-1:0]  prod;
  logic [OUTWIDTH-1:0] acc, fmad_q, p_ext, c_ext, op_x, op_y;
  logic [OUTWIDTH:0]   sum;
  logic                sub, ovf, ovf_q;

  assign transfer     = bus.inValid && in_ready;
  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.fmadOut  = fmad_q;
  assign bus.overflow = ovf_q;

  radix4_booth_mul #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (transfer),
    .mulIn1 (bus.mulIn1),
    .mulIn2 (bus.mulIn2),
    .mulOut (prod),
    .done   (mul_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= FMAC_IDLE;
    else       state <= state_nxt;
  end

  // A held result can be retired and a new operation taken on the same edge.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FMAC_IDLE: begin
        in_ready = 1'b1;
        if (bus.inValid) state_nxt = FMAC_MUL;
      end
      FMAC_MUL:  if (mul_done) state_nxt = FMAC_ADD;
      FMAC_ADD:  state_nxt = FMAC_DONE;
      FMAC_DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.outReady;
        if (bus.outReady) state_nxt = bus.inValid ? FMAC_MUL : FMAC_IDLE;
      end
      default:   state_nxt = FMAC_IDLE;
    endcase
  end

  always_comb begin
    p_ext = {{GUARD{S & prod[2*WIDTH-1]}}, prod};
    c_ext = {{(OUTWIDTH-WIDTH){S & req.c[WIDTH-1]}}, req.c};
    op_x  = p_ext;
    op_y  = c_ext;
    sub   = 1'b0;
    case (req.mode)
      FMAC_MAD:  begin op_x = p_ext; op_y = c_ext; sub = 1'b0; end
      FMAC_MSB:  begin op_x = p_ext; op_y = c_ext; sub = 1'b1; end
      FMAC_NMAD: begin op_x = c_ext; op_y = p_ext; sub = 1'b1; end
      FMAC_MAC:  begin op_x = req.clr ? '0 : acc; op_y = p_ext; sub = 1'b0; end
      default:   begin op_x = p_ext; op_y = c_ext; sub = 1'b0; end
    endcase
    sum = sub ? ({1'b0, op_x} - {1'b0, op_y}) : ({1'b0, op_x} + {1'b0, op_y});
    // Unsigned: the extra bit is carry (add) or borrow (sub). Signed: sign overflow.
    if (S) begin
      if (sub) ovf = (op_x[OUTWIDTH-1] != op_y[OUTWIDTH-1]) && (sum[OUTWIDTH-1] != op_x[OUTWIDTH-1]);
      else     ovf = (op_x[OUTWIDTH-1] == op_y[OUTWIDTH-1]) && (sum[OUTWIDTH-1] != op_x[OUTWIDTH-1]);
    end else begin
      ovf = sum[OUTWIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req    <= '0;
      acc    <= '0;
      fmad_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (transfer) req <= '{c: bus.addIn, mode: bus.mode, clr: bus.accClear};
      if (state == FMAC_ADD) begin
        fmad_q <= sum[OUTWIDTH-1:0];
        ovf_q  <= ovf;
        if (req.mode == FMAC_MAC) acc <= sum[OUTWIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fmac_unit.sv
// Drives an unsigned and a signed fmac_unit with identical stimulus and checks both against an integer model.
module tb_fmac_unit;
  import fmac_pkg::*;

  localparam int W  = 11;
  localparam int G  = 4;
  localparam int OW = 2*W + G;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, acc_clr = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a_v = '0, b_v = '0, c_v = '0;
  logic [1:0]   mode_v = '0;

  fmac_if #(.WIDTH(W), .GUARD(G)) bu();
  fmac_if #(.WIDTH(W), .GUARD(G)) bs();

  assign bu.inValid  = in_valid;  assign bs.inValid  = in_valid;
  assign bu.mulIn1   = a_v;       assign bs.mulIn1   = a_v;
  assign bu.mulIn2   = b_v;       assign bs.mulIn2   = b_v;
  assign bu.addIn    = c_v;       assign bs.addIn    = c_v;
  assign bu.mode     = fmacMode_t'(mode_v);
  assign bs.mode     = fmacMode_t'(mode_v);
  assign bu.accClear = acc_clr;   assign bs.accClear = acc_clr;
  assign bu.outReady = out_ready; assign bs.outReady = out_ready;

  fmac_unit #(.WIDTH(W), .GUARD(G), .SIGNED(0)) u_uns (.clock(clk), .reset(rst), .bus(bu));
  fmac_unit #(.WIDTH(W), .GUARD(G), .SIGNED(1)) u_sgn (.clock(clk), .reset(rst), .bus(bs));

  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint acc_u = 0, acc_s = 0;   // accumulator bit patterns
  longint eu = 0, es = 0;
  logic   ou = 0, os = 0;
  logic [OW-1:0] last_u, last_s;
  logic          last_ou, last_os;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return v[w-1] ? v - (longint'(1) << w) : v;
  endfunction

  // Exact integer evaluation, then reduce modulo 2^OW; overflow = result out of range.
  task automatic model(input logic [W-1:0] a, b, c, input logic [1:0] m, input logic clr);
    longint av, bv, cv, accv, p, r, mask, lim;
    mask = (longint'(1) << OW) - 1;
    lim  = longint'(1) << (OW-1);
    for (int s = 0; s < 2; s++) begin
      av   = s ? sx(longint'(a), W) : longint'(a);
      bv   = s ? sx(longint'(b), W) : longint'(b);
      cv   = s ? sx(longint'(c), W) : longint'(c);
      accv = s ? sx(acc_s, OW) : acc_u;
      p    = av * bv;
      case (m)
        2'd0:    r = p + cv;
        2'd1:    r = p - cv;
        2'd2:    r = cv - p;
        default: r = (clr ? 0 : accv) + p;
      endcase
      if (s == 0) begin
        eu = r & mask;
        ou = (r < 0) || (r > mask);
        if (m == 2'd3) acc_u = eu;
      end else begin
        es = r & mask;
        os = (r < -lim) || (r >= lim);
        if (m == 2'd3) acc_s = es;
      end
    end
  endtask

  task automatic issue(input logic [W-1:0] a, b, c, input logic [1:0] m, input logic clr);
    int n = 0;
    a_v = a; b_v = b; c_v = c; mode_v = m; acc_clr = clr; in_valid = 1'b1;
    #1;
    while (!bu.inReady && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    a_v = W'($urandom); b_v = W'($urandom); c_v = W'($urandom);
    mode_v = 2'($urandom); acc_clr = 1'($urandom);
    model(a, b, c, m, clr);
  endtask

  task automatic finish(input int stall, input bit chain,
                        input logic [W-1:0] a, b, c, input logic [1:0] m, input logic clr);
    int n = 0;
    logic [OW-1:0] hold;
    while (!bu.outValid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", 64'(cyc - acc_cyc), 64'd7);
    chk("u_res", 64'(bu.fmadOut), 64'(eu));
    chk("u_ovf", 64'(bu.overflow), 64'(ou));
    chk("s_vld", 64'(bs.outValid), 64'd1);
    chk("s_res", 64'(bs.fmadOut), 64'(es));
    chk("s_ovf", 64'(bs.overflow), 64'(os));
    last_u = bu.fmadOut; last_s = bs.fmadOut; last_ou = bu.overflow; last_os = bs.overflow;
    hold = bu.fmadOut;
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_vld", 64'(bu.outValid), 64'd1);
      chk("stall_hold", 64'(bu.fmadOut), 64'(hold));
      chk("stall_rdy", 64'(bu.inReady), 64'd0);
    end
    out_ready = 1'b1;
    if (chain) begin
      a_v = a; b_v = b; c_v = c; mode_v = m; acc_clr = clr; in_valid = 1'b1;
      #1;
      chk("chain_rdy", 64'(bu.inReady), 64'd1);
      @(posedge clk); #1;
      acc_cyc = cyc;
      chk("chain_vld_drop", 64'(bu.outValid), 64'd0);
      chk("chain_busy", 64'(bu.inReady), 64'd0);
      in_valid = 1'b0;
      model(a, b, c, m, clr);
    end else begin
      @(posedge clk); #1;
      chk("vld_drop", 64'(bu.outValid), 64'd0);
    end
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return W'(1) << (W-1);
      2:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb, rc;
    logic [1:0]   rm;
    logic         rcl, ch;
    int           seen;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out", 64'(bu.fmadOut), 64'd0);
    chk("rst_ovf", 64'(bu.overflow), 64'd0);
    chk("rst_vld", 64'(bu.outValid), 64'd0);
    chk("rst_rdy", 64'(bu.inReady), 64'd1);

    issue(11'd2047, 11'd2047, 11'd5, 2'd0, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mad", 64'(last_u), 64'd4190214); chk("tp_mad_ovf", 64'(last_ou), 64'd0);
    issue(11'd3, 11'd4, 11'd20, 2'd1, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_msb", 64'(last_u), 64'h3FFFFF8); chk("tp_msb_ovf", 64'(last_ou), 64'd1);
    issue(11'h7FD, 11'd5, 11'd7, 2'd2, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_nmad_s", 64'(last_s), 64'd22); chk("tp_nmad_s_ovf", 64'(last_os), 64'd0);
    issue(11'h400, 11'h400, 11'd0, 2'd0, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mad_s_neg", 64'(last_s), 64'd1048576);

    issue(11'd10, 11'd10, 11'd99, 2'd3, 1'b1); finish(1, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mac1", 64'(last_u), 64'd100);
    issue(11'd20, 11'd20, 11'd99, 2'd3, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mac2", 64'(last_u), 64'd500);
    issue(11'd30, 11'd30, 11'd99, 2'd3, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mac3", 64'(last_u), 64'd1400); chk("tp_mac3_s", 64'(last_s), 64'd1400);
    issue(11'd1, 11'd1, 11'd1, 2'd0, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mad_mid", 64'(last_u), 64'd2);
    issue(11'd1, 11'd1, 11'd0, 2'd3, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_mac4", 64'(last_u), 64'd1401);

    // Backpressure for 5 cycles, then retire and accept on the same edge.
    issue(11'd7, 11'd9, 11'd3, 2'd0, 1'b0);
    finish(5, 1, 11'd12, 11'd12, 11'd1, 2'd0, 1'b0);
    finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_chain", 64'(last_u), 64'd145);

    // Reset in the third multiply cycle discards the operation and the accumulator.
    issue(11'd5, 11'd5, 11'd5, 2'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_u = 0; acc_s = 0;
    chk("mid_rst_vld", 64'(bu.outValid), 64'd0);
    chk("mid_rst_out", 64'(bu.fmadOut), 64'd0);
    chk("mid_rst_rdy", 64'(bu.inReady), 64'd1);
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (bu.outValid || bs.outValid) seen++; end
    chk("mid_rst_no_result", 64'(seen), 64'd0);
    issue(11'd2, 11'd3, 11'd0, 2'd3, 1'b0); finish(0, 0, '0, '0, '0, 2'd0, 1'b0);
    chk("tp_rst_mac", 64'(last_u), 64'd6); chk("tp_rst_mac_s", 64'(last_s), 64'd6);

    // Random operations with random stalls and chained handoffs.
    ra = rnd_op(); rb = rnd_op(); rc = rnd_op(); rm = 2'($urandom); rcl = ($urandom_range(0, 3) == 0);
    issue(ra, rb, rc, rm, rcl);
    for (int i = 0; i < 40; i++) begin
      ra = rnd_op(); rb = rnd_op(); rc = rnd_op(); rm = 2'($urandom); rcl = ($urandom_range(0, 3) == 0);
      ch = (i < 39) && ($urandom_range(0, 1) == 1);
      finish($urandom_range(0, 2), ch, ra, rb, rc, rm, rcl);
      if (!ch && i < 39) issue(ra, rb, rc, rm, rcl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
